fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 152 +++++++++++++++
 tb/tb_fetch_unit.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch unit: PC sequencing, cache handshake, redirect, instruction queue
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] fetch_adr_o,
  output logic        fetch_req_o,
  input  logic [31:0] ins_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        dec_valid_o,
  output logic [31:0] dec_ins_o,
  output logic [31:0] dec_pc_o,
  input  logic        dec_ready_i
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {RUN, DROP} state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q;
  logic [31:0]   pend_q;
  logic [CW-1:0] count_q;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [31:0]   q_ins [QDEPTH];
  logic [31:0]   q_pc  [QDEPTH];

  logic [31:0]   target;
  logic          stalled_req;
  logic          push;
  logic          pop;

  // Redirect targets are always word aligned.
  assign target = {redirect_pc_i[31:2], 2'b00};

  // The PC register is the fetch address in both states; in DROP it still
  // holds the address of the stalled request being thrown away.
  assign fetch_adr_o = pc_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and request: a redirect that lands on a stalled request must
  // wait for that request to retire, so it parks in DROP.
  always_comb begin
    state_d     = state_q;
    fetch_req_o = 1'b0;
    case (state_q)
      RUN: begin
        fetch_req_o = (count_q < CW'(QDEPTH));
        if (redirect_i && fetch_req_o && stall_i) begin
          state_d = DROP;
        end
      end
      DROP: begin
        fetch_req_o = 1'b1;
        if (!stall_i) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
    if (rst) begin
      fetch_req_o = 1'b0;
    end
  end

  // Queue handshakes; a redirect cancels both the push and the pop.
  assign stalled_req = fetch_req_o && stall_i;
  assign push        = (state_q == RUN) && fetch_req_o && !stall_i && !redirect_i;
  assign pop         = dec_valid_o && dec_ready_i && !redirect_i;

  // PC, pending target, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      pend_q   <= 32'h0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (redirect_i) begin
        count_q  <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
        case ({push, pop})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end

      case (state_q)
        RUN: begin
          if (redirect_i) begin
            if (stalled_req) begin
              pend_q <= target;
            end else begin
              pc_q <= target;
            end
          end else if (push) begin
            pc_q <= pc_q + 32'd4;
          end
        end
        DROP: begin
          if (redirect_i) begin
            pend_q <= target;
          end
          if (!stall_i) begin
            pc_q <= redirect_i ? target : pend_q;
          end
        end
        default: begin
          pc_q <= pc_q;
        end
      endcase
    end
  end

  // Queue storage; entries are only visible while counted, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      q_ins[wr_ptr_q] <= ins_i;
      q_pc[wr_ptr_q]  <= pc_q;
    end
  end

  assign dec_valid_o = (count_q != '0);
  assign dec_ins_o   = dec_valid_o ? q_ins[rd_ptr_q] : 32'h0;
  assign dec_pc_o    = dec_valid_o ? q_pc[rd_ptr_q]  : 32'h0;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized and directed bench for fetch_unit against a queue-based model
module tb_fetch_unit;

  localparam int          QD      = 4;
  localparam logic [31:0] K       = 32'hA5A5_A5A5;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_adr_o, w_adr;
  logic        fetch_req_o, w_req;
  logic [31:0] ins_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        dec_valid_o, w_valid;
  logic [31:0] dec_ins_o, w_ins;
  logic [31:0] dec_pc_o, w_pc;
  logic        dec_ready_i;
  logic        sel_wrap = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference model: instruction queue of {pc, ins}, current PC, pending target.
  logic [63:0] mq [$];
  logic [31:0] m_pc;
  logic [31:0] m_pend;
  bit          m_drop;

  always #5 clk = ~clk;

  // Cache model: the instruction at an address is address ^ K.
  assign ins_i = (sel_wrap ? w_adr : fetch_adr_o) ^ K;

  fetch_unit u_dut (
    .clk(clk), .rst(rst), .fetch_adr_o(fetch_adr_o), .fetch_req_o(fetch_req_o),
    .ins_i(ins_i), .stall_i(stall_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .dec_valid_o(dec_valid_o), .dec_ins_o(dec_ins_o), .dec_pc_o(dec_pc_o), .dec_ready_i(dec_ready_i)
  );

  fetch_unit #(.RESET_PC(WRAP_PC)) u_wrap (
    .clk(clk), .rst(rst), .fetch_adr_o(w_adr), .fetch_req_o(w_req),
    .ins_i(ins_i), .stall_i(stall_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .dec_valid_o(w_valid), .dec_ins_o(w_ins), .dec_pc_o(w_pc), .dec_ready_i(dec_ready_i)
  );

  function automatic bit m_req();
    return m_drop || (mq.size() < QD);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pc   = 32'h0;
    m_pend = 32'h0;
    m_drop = 1'b0;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    dec_ready_i   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst = 1'b0;
  endtask

  // One clock edge with the given inputs; the model advances by the rules.
  task automatic tick(input bit st, input bit rd, input logic [31:0] tgt, input bit rdy);
    logic [31:0] t;
    bit          req;
    stall_i       = st;
    redirect_i    = rd;
    redirect_pc_i = tgt;
    dec_ready_i   = rdy;
    t   = {tgt[31:2], 2'b00};
    req = m_req();
    @(posedge clk);
    if (m_drop) begin
      if (rd) m_pend = t;
      if (!st) begin
        m_pc   = m_pend;
        m_drop = 1'b0;
      end
    end else if (rd) begin
      mq.delete();
      if (req && st) begin
        m_pend = t;
        m_drop = 1'b1;
      end else begin
        m_pc = t;
      end
    end else begin
      if (mq.size() != 0 && rdy) void'(mq.pop_front());
      if (req && !st) begin
        mq.push_back({m_pc, m_pc ^ K});
        m_pc = m_pc + 32'd4;
      end
    end
    @(negedge clk);
    redirect_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0; dec_ready_i = 1'b0;
    #1;
    checks++;
    if (fetch_req_o !== 1'b0 || dec_valid_o !== 1'b0) begin
      errors++; $display("FAIL reset_ctl: req=%b valid=%b expected 0 0", fetch_req_o, dec_valid_o);
    end
    checks++;
    if (fetch_adr_o !== 32'h0 || w_adr !== WRAP_PC) begin
      errors++; $display("FAIL reset_adr: adr=%h wrap_adr=%h expected 0 %h", fetch_adr_o, w_adr, WRAP_PC);
    end
    checks++;
    if (dec_ins_o !== 32'h0 || dec_pc_o !== 32'h0) begin
      errors++; $display("FAIL reset_dec: ins=%h pc=%h expected 0 0", dec_ins_o, dec_pc_o);
    end
    @(negedge clk);
    model_reset();
    rst = 1'b0;
    #1;
    checks++;
    if (fetch_req_o !== 1'b1 || fetch_adr_o !== 32'h0) begin
      errors++; $display("FAIL reset_release: req=%b adr=%h expected 1 0", fetch_req_o, fetch_adr_o);
    end
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      checks++;
      if (dec_valid_o !== 1'b1 || dec_pc_o !== 32'(4 * i) || dec_ins_o !== (32'(4 * i) ^ K)) begin
        errors++;
        $display("FAIL stream[%0d]: valid=%b pc=%h ins=%h expected 1 %h %h",
                 i, dec_valid_o, dec_pc_o, dec_ins_o, 32'(4 * i), 32'(4 * i) ^ K);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] next_pc;
    do_reset();
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 32'h0, 1'b0);
    checks++;
    if (fetch_req_o !== 1'b0 || fetch_adr_o !== 32'h10 || dec_valid_o !== 1'b1 || dec_pc_o !== 32'h0) begin
      errors++;
      $display("FAIL bp_full: req=%b adr=%h valid=%b pc=%h expected 0 00000010 1 0",
               fetch_req_o, fetch_adr_o, dec_valid_o, dec_pc_o);
    end
    next_pc = 32'h0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (dec_valid_o !== 1'b1 || dec_pc_o !== next_pc) begin
        errors++; $display("FAIL bp_order[%0d]: valid=%b pc=%h expected 1 %h", i, dec_valid_o, dec_pc_o, next_pc);
      end
      next_pc = next_pc + 32'd4;
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      checks++;
      if (fetch_req_o !== m_req() || fetch_adr_o !== m_pc) begin
        errors++; $display("FAIL bp_fetch[%0d]: req=%b adr=%h expected %b %h", i, fetch_req_o, fetch_adr_o, m_req(), m_pc);
      end
    end
  endtask

  task automatic test_redirect_hit();
    do_reset();
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 32'h0, 1'b0);
    tick(1'b0, 1'b1, 32'h0000_1003, 1'b1);
    checks++;
    if (dec_valid_o !== 1'b0 || fetch_adr_o !== 32'h1000 || fetch_req_o !== 1'b1) begin
      errors++;
      $display("FAIL hit_flush: valid=%b adr=%h req=%b expected 0 00001000 1", dec_valid_o, fetch_adr_o, fetch_req_o);
    end
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      checks++;
      if (dec_valid_o !== 1'b1 || dec_pc_o !== 32'h1000 + 32'(4 * i) || dec_ins_o !== ((32'h1000 + 32'(4 * i)) ^ K)) begin
        errors++;
        $display("FAIL hit_next[%0d]: valid=%b pc=%h ins=%h expected 1 %h", i, dec_valid_o, dec_pc_o, dec_ins_o,
                 32'h1000 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_redirect_miss();
    do_reset();
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if (fetch_adr_o !== 32'h20) begin
      errors++; $display("FAIL miss_setup: adr=%h expected 00000020", fetch_adr_o);
    end
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, (i == 0) || (i == 2), (i == 0) ? 32'h400 : 32'h800, 1'b1);
      checks++;
      if (fetch_adr_o !== 32'h20 || fetch_req_o !== 1'b1 || dec_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL miss_hold[%0d]: adr=%h req=%b valid=%b expected 00000020 1 0",
                 i, fetch_adr_o, fetch_req_o, dec_valid_o);
      end
    end
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if (fetch_adr_o !== 32'h800 || dec_valid_o !== 1'b0) begin
      errors++; $display("FAIL miss_resume: adr=%h valid=%b expected 00000800 0", fetch_adr_o, dec_valid_o);
    end
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if (dec_valid_o !== 1'b1 || dec_pc_o !== 32'h800 || dec_ins_o !== (32'h800 ^ K)) begin
      errors++; $display("FAIL miss_first: valid=%b pc=%h ins=%h expected 1 00000800", dec_valid_o, dec_pc_o, dec_ins_o);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'hFFFF_FFF8;
    exp_pc[1] = 32'hFFFF_FFFC;
    exp_pc[2] = 32'h0000_0000;
    sel_wrap = 1'b1;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      checks++;
      if (w_valid !== 1'b1 || w_pc !== exp_pc[i] || w_ins !== (exp_pc[i] ^ K)) begin
        errors++; $display("FAIL wrap[%0d]: valid=%b pc=%h ins=%h expected 1 %h", i, w_valid, w_pc, w_ins, exp_pc[i]);
      end
    end
    sel_wrap = 1'b0;
  endtask

  task automatic test_reset_drop();
    do_reset();
    tick(1'b0, 1'b0, 32'h0, 1'b0);
    tick(1'b0, 1'b0, 32'h0, 1'b0);
    tick(1'b1, 1'b1, 32'h300, 1'b1);
    tick(1'b1, 1'b0, 32'h0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (fetch_req_o !== 1'b0 || dec_valid_o !== 1'b0 || fetch_adr_o !== 32'h0) begin
      errors++;
      $display("FAIL drop_reset: req=%b valid=%b adr=%h expected 0 0 0", fetch_req_o, dec_valid_o, fetch_adr_o);
    end
    @(negedge clk);
    model_reset();
    stall_i = 1'b0;
    rst = 1'b0;
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if (dec_valid_o !== 1'b1 || dec_pc_o !== 32'h0 || fetch_adr_o !== 32'h4) begin
      errors++;
      $display("FAIL drop_restart: valid=%b pc=%h adr=%h expected 1 0 4", dec_valid_o, dec_pc_o, fetch_adr_o);
    end
  endtask

  task automatic test_random();
    bit st = 1'b0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) st = ~st;
      tick(st, $urandom_range(0, 11) == 0, $urandom, $urandom_range(0, 2) != 0);
      checks++;
      if (fetch_req_o !== m_req() || fetch_adr_o !== m_pc) begin
        errors++;
        $display("FAIL rand_fetch[%0d]: req=%b adr=%h expected %b %h", i, fetch_req_o, fetch_adr_o, m_req(), m_pc);
      end
      checks++;
      if (dec_valid_o !== (mq.size() != 0)) begin
        errors++; $display("FAIL rand_valid[%0d]: valid=%b expected %b", i, dec_valid_o, mq.size() != 0);
      end else if (mq.size() != 0) begin
        if ({dec_pc_o, dec_ins_o} !== mq[0]) begin
          errors++;
          $display("FAIL rand_head[%0d]: pc=%h ins=%h expected %h %h", i, dec_pc_o, dec_ins_o, mq[0][63:32], mq[0][31:0]);
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_hit();
    test_redirect_miss();
    test_wrap();
    test_reset_drop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
